// File: rtl/muldiv_pkg.sv
// Shared encodings and operand-sign helpers
// for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV)  || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next
// dividend bit and subtract the divisor if it fits.
module div_step #(
  parameter int W = 33
) (
  input  logic [W-2:0] rem_i,
  input  logic         bit_i,
  input  logic [W-2:0] dvs_i,
  output logic [W-2:0] rem_o,
  output logic         q_o
);

  logic [W-1:0] sh;

  assign sh    = {rem_i, bit_i};
  assign q_o   = (sh >= {1'b0, dvs_i});
  // The difference is below the divisor, so it fits W-1 bits.
  assign rem_o = q_o ? (sh[W-2:0] - dvs_i) : sh[W-2:0];

endmodule

// File: rtl/iter_muldiv.sv
// Iterative RV32M multiply/divide unit, one
// shift-add or restoring step per cycle.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, hi_q, lo_q, res_q;
  logic            neg_q, nega_q;
  logic [CW-1:0]   cnt_q;

  logic            sa, sb, zdiv, ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;

  assign sa    = a_signed(op) & a[XLEN-1];
  assign sb    = b_signed(op) & b[XLEN-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;
  assign zdiv  = is_div(op) && (b == '0);
  assign ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                 (a == MIN) && (b == ONES);
  assign special = zdiv || ovf;

  // Results for operations that skip iteration.
  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      zdiv:    spec_res = op[1] ? a : ONES;
      ovf:     spec_res = op[1] ? '0 : a;
      default: spec_res = '0;
    endcase
  end

  logic [XLEN:0]   msum;
  logic [XLEN-1:0] drem, hi_d, lo_d;
  logic            dq;

  assign msum = {1'b0, hi_q} +
                (lo_q[0] ? {1'b0, a_q} : '0);

  div_step #(.W(XLEN + 1)) u_div (
    .rem_i (hi_q),
    .bit_i (lo_q[XLEN-1]),
    .dvs_i (b_q),
    .rem_o (drem),
    .q_o   (dq)
  );

  // Next partial state: hi holds product-high or
  // remainder, lo holds multiplier or dividend/quotient.
  always_comb begin
    if (is_div(op_q)) begin
      hi_d = drem;
      lo_d = {lo_q[XLEN-2:0], dq};
    end else begin
      hi_d = msum[XLEN:1];
      lo_d = {msum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fin;

  assign prod   = {hi_d, lo_d};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo_d : lo_d;
  assign rem    = nega_q ? -hi_d : hi_d;

  // Select the final value from the last step.
  always_comb begin
    fin = '0;
    case (op_q)
      OP_MUL:  fin = prod_s[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU: fin = prod_s[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU: fin = quo;
      default: fin = rem;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op_q   <= op;
          a_q    <= mag_a;
          b_q    <= mag_b;
          neg_q  <= sa ^ sb;
          nega_q <= sa;
          hi_q   <= '0;
          lo_q   <= is_div(op) ? mag_a : mag_b;
          cnt_q  <= '0;
          if (special) begin
            res_q   <= spec_res;
            state_q <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            res_q   <= fin;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) begin
          res_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) ||
                     ((state_q == DONE) && !out_ready);
  assign result    = res_q;

endmodule
